// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - default geometry/timing and width helpers for the dot-matrix scan driver
package dot_pkg;

    localparam int ROWS_DEF         = 10;
    localparam int COLS_DEF         = 14;
    localparam int DIV_DEF          = 12500;
    localparam int BLINK_FRAMES_DEF = 25;

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int col_w(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_div.sv
// rtl/tick_div.sv - free-running prescaler, tick high on the last count of each DIV period
module tick_div
    import dot_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic freq,
    input  logic rst,
    output logic tick
);

    localparam int CW = cnt_w(DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge freq or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dot_scan_ctrl.sv
// rtl/dot_scan_ctrl.sv - double-buffered row scanner with frame-aligned swap and column blinking
module dot_scan_ctrl
    import dot_pkg::*;
#(
    parameter int ROWS         = ROWS_DEF,
    parameter int COLS         = COLS_DEF,
    parameter int DIV          = DIV_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                     freq,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [row_w(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]          wr_data,
    input  logic                     swap_req,
    output logic                     swap_pend,
    input  logic                     blink_en,
    input  logic [COLS-1:0]          blink_mask,
    output logic [ROWS-1:0]          dot_row,
    output logic [COLS-1:0]          dot_col,
    output logic                     frame_start
);

    localparam int RW = row_w(ROWS);
    localparam int FW = cnt_w(BLINK_FRAMES);

    logic                tick;
    logic [COLS-1:0]     fb [2][ROWS];
    logic                front_sel;
    logic [RW-1:0]       ridx;
    logic [FW-1:0]       fcnt;
    logic                blink_phase;

    logic                frame_edge;
    logic                next_front;
    logic [RW-1:0]       next_ridx;
    logic                fcnt_wrap;
    logic                next_phase;
    logic [COLS-1:0]     row_data;
    logic [COLS-1:0]     load_col;
    logic                wr_ok;

    tick_div #(.DIV(DIV)) u_tick_div (
        .freq (freq),
        .rst  (rst),
        .tick (tick)
    );

    // Row 0 of a new frame is fetched with the post-edge front select and blink
    // phase, so every row of a frame shows the same buffer and the same phase.
    always_comb begin
        frame_edge = tick && (ridx == RW'(ROWS - 1));
        next_front = front_sel ^ (frame_edge && swap_pend);
        next_ridx  = frame_edge ? '0 : ridx + 1'b1;
        fcnt_wrap  = (fcnt == FW'(BLINK_FRAMES - 1));
        next_phase = (frame_edge && fcnt_wrap) ? ~blink_phase : blink_phase;
        row_data   = fb[next_front][next_ridx];
        load_col   = (blink_en && next_phase) ? (row_data & ~blink_mask) : row_data;
        wr_ok      = wr_en && (int'(wr_row) < ROWS);
    end

    always_ff @(posedge freq or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                fb[0][r] <= '0;
                fb[1][r] <= '0;
            end
            front_sel   <= 1'b0;
            ridx        <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            swap_pend   <= 1'b0;
            dot_row     <= ROWS'(1);
            dot_col     <= '0;
            frame_start <= 1'b0;
        end else begin
            // Writes follow the pre-edge back buffer, even on a swap edge.
            if (wr_ok) begin
                fb[~front_sel][wr_row] <= wr_data;
            end

            frame_start <= frame_edge;

            if (tick) begin
                ridx    <= next_ridx;
                dot_row <= ROWS'(1) << next_ridx;
                dot_col <= load_col;
            end

            if (frame_edge) begin
                front_sel   <= next_front;
                blink_phase <= next_phase;
                fcnt        <= fcnt_wrap ? '0 : fcnt + 1'b1;
            end

            if (swap_pend) begin
                if (frame_edge) begin
                    swap_pend <= 1'b0;
                end
            end else if (swap_req) begin
                swap_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// tb/tb_dot_scan_ctrl.sv - randomized self-checking bench for dot_scan_ctrl against a cycle-count model
module tb_dot_scan_ctrl;

    localparam int ROWS = 10;
    localparam int COLS = 14;
    localparam int DIV  = 4;
    localparam int BF   = 2;
    localparam int FRM  = DIV * ROWS;

    logic              freq = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [3:0]        wr_row = '0;
    logic [COLS-1:0]   wr_data = '0;
    logic              swap_req = 1'b0;
    logic              blink_en = 1'b0;
    logic [COLS-1:0]   blink_mask = '0;
    logic              swap_pend;
    logic [ROWS-1:0]   dot_row;
    logic [COLS-1:0]   dot_col;
    logic              frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edges since reset release, buffers, front index, pending flag.
    logic [COLS-1:0]   m_buf [2][ROWS];
    int                m_front;
    bit                m_pend;
    int                n;
    logic [ROWS-1:0]   e_row;
    logic [COLS-1:0]   e_col;
    bit                e_fs;

    dot_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLINK_FRAMES(BF)
    ) dut (
        .freq        (freq),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_pend   (swap_pend),
        .blink_en    (blink_en),
        .blink_mask  (blink_mask),
        .dot_row     (dot_row),
        .dot_col     (dot_col),
        .frame_start (frame_start)
    );

    always #5 freq = ~freq;

    function automatic int cur_row();
        return (n / DIV) % ROWS;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < ROWS; r++)
                m_buf[s][r] = '0;
        m_front = 0;
        m_pend  = 0;
        n       = 0;
        e_row   = ROWS'(1);
        e_col   = '0;
        e_fs    = 0;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_row = '0; wr_data = '0; swap_req = 0;
    endtask

    // Advance one clock; the model is computed from the absolute edge count.
    task automatic step();
        int pf, row;
        bit tk, fedge, ph;
        logic [COLS-1:0] v;
        @(posedge freq);
        n++;
        pf    = m_front;
        tk    = (n % DIV) == 0;
        row   = (n / DIV) % ROWS;
        fedge = tk && (row == 0);
        if (m_pend) begin
            if (fedge) begin
                m_front = 1 - m_front;
                m_pend  = 0;
            end
        end else if (swap_req) begin
            m_pend = 1;
        end
        e_fs = fedge;
        if (tk) begin
            ph = (((n / FRM) / BF) % 2) == 1;
            v  = m_buf[m_front][row];
            if (blink_en && ph) v = v & ~blink_mask;
            e_row = ROWS'(1 << row);
            e_col = v;
        end
        if (wr_en && int'(wr_row) < ROWS) m_buf[1 - pf][wr_row] = wr_data;
        @(negedge freq);
    endtask

    task automatic do_reset();
        idle_inputs();
        blink_en = 0; blink_mask = '0;
        rst = 1;
        m_reset();
        @(negedge freq);
        rst = 0;
    endtask

    task automatic wait_row(input int r, output bit ok);
        ok = 0;
        for (int k = 0; k < 2 * FRM; k++) begin
            if (cur_row() == r) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1;
        #1;
        n_cmp++;
        if (dot_row !== 10'd1 || dot_col !== 14'd0 || swap_pend !== 1'b0 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values row %h col %h pend %b fs %b, want 001 0000 0 0", dot_row, dot_col, swap_pend, frame_start);
        end
        m_reset();
        @(negedge freq);
        rst = 0;
        for (int i = 1; i <= 41; i++) begin
            step();
            n_cmp++;
            if (dot_row !== e_row || dot_col !== e_col || frame_start !== e_fs || swap_pend !== m_pend) begin
                n_bad++;
                $display("FAIL reset_scan n=%0d row %h/%h col %h/%h fs %b/%b pend %b/%b", n, dot_row, e_row, dot_col, e_col, frame_start, e_fs, swap_pend, m_pend);
            end
            if (i == 4 || i == 36 || i == 40 || i == 41) begin
                n_cmp++;
                if ((i == 4  && dot_row !== 10'd2) ||
                    (i == 36 && dot_row !== 10'd512) ||
                    (i == 40 && (dot_row !== 10'd1 || frame_start !== 1'b1)) ||
                    (i == 41 && frame_start !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL reset_timing edge %0d row %h fs %b", i, dot_row, frame_start);
                end
            end
        end
    endtask

    task automatic test_no_swap();
        wr_en = 1; wr_row = 4'd0; wr_data = 14'h02A5;
        step();
        idle_inputs();
        for (int i = 0; i < 2 * FRM; i++) begin
            step();
            n_cmp++;
            if (dot_col !== 14'd0 || dot_row !== e_row || frame_start !== e_fs || swap_pend !== m_pend) begin
                n_bad++;
                $display("FAIL no_swap n=%0d col %h want 0000 row %h/%h fs %b/%b pend %b/%b", n, dot_col, dot_row, e_row, frame_start, e_fs, swap_pend, m_pend);
            end
        end
    endtask

    task automatic test_swap();
        bit ok;
        for (int r = 0; r < ROWS; r++) begin
            wr_en = 1; wr_row = 4'(r); wr_data = 14'h3FFF;
            step();
        end
        idle_inputs();
        wait_row(4, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL swap_wait timeout n=%0d", n); end
        swap_req = 1;
        step();
        swap_req = 0;
        n_cmp++;
        if (swap_pend !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_pend_set got %b want 1", swap_pend);
        end
        for (int i = 0; i < FRM + 5; i++) begin
            step();
            n_cmp++;
            if (dot_row !== e_row || dot_col !== e_col || frame_start !== e_fs || swap_pend !== m_pend) begin
                n_bad++;
                $display("FAIL swap n=%0d row %h/%h col %h/%h fs %b/%b pend %b/%b", n, dot_row, e_row, dot_col, e_col, frame_start, e_fs, swap_pend, m_pend);
            end
        end
        n_cmp++;
        if (dot_col !== 14'h3FFF || swap_pend !== 1'b0) begin
            n_bad++;
            $display("FAIL swap_visible col %h pend %b want 3fff 0", dot_col, swap_pend);
        end
    endtask

    task automatic test_double_swap();
        logic [COLS-1:0] pat [ROWS];
        bit ok;
        for (int r = 0; r < ROWS; r++) begin
            pat[r] = COLS'($urandom);
            wr_en = 1; wr_row = 4'(r); wr_data = pat[r];
            step();
        end
        idle_inputs();
        wait_row(2, ok);
        swap_req = 1; step(); swap_req = 0;
        wait_row(6, ok);
        swap_req = 1; step(); swap_req = 0;
        for (int i = 0; i < 2 * FRM; i++) begin
            step();
            n_cmp++;
            if (dot_row !== e_row || dot_col !== e_col || frame_start !== e_fs || swap_pend !== m_pend) begin
                n_bad++;
                $display("FAIL double_swap n=%0d row %h/%h col %h/%h fs %b/%b pend %b/%b", n, dot_row, e_row, dot_col, e_col, frame_start, e_fs, swap_pend, m_pend);
            end
        end
        wait_row(3, ok);
        n_cmp++;
        if (!ok || dot_col !== pat[3] || swap_pend !== 1'b0) begin
            n_bad++;
            $display("FAIL double_swap_once col %h want %h pend %b", dot_col, pat[3], swap_pend);
        end
    endtask

    task automatic test_blink();
        int n_off;
        for (int r = 0; r < ROWS; r++) begin
            wr_en = 1; wr_row = 4'(r); wr_data = 14'h3FFF;
            step();
        end
        idle_inputs();
        swap_req = 1; step(); swap_req = 0;
        blink_en = 1; blink_mask = 14'h0007;
        for (int k = 0; k < 3 * FRM && !(n % FRM == 0 && !m_pend); k++) step();
        n_off = 0;
        for (int i = 0; i < 4 * FRM; i++) begin
            if (i > 0) step();
            if (dot_col === 14'h3FF8) n_off++;
            n_cmp++;
            if (dot_row !== e_row || dot_col !== e_col || frame_start !== e_fs || swap_pend !== m_pend) begin
                n_bad++;
                $display("FAIL blink n=%0d row %h/%h col %h/%h fs %b/%b", n, dot_row, e_row, dot_col, e_col, frame_start, e_fs);
            end
        end
        n_cmp++;
        if (n_off !== 2 * FRM) begin
            n_bad++;
            $display("FAIL blink_duty off-cycles %0d want %0d", n_off, 2 * FRM);
        end
        blink_en = 0; blink_mask = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            wr_en    = $urandom_range(0, 1);
            wr_row   = 4'($urandom_range(0, 15));
            wr_data  = COLS'($urandom);
            swap_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 49) == 0) blink_mask = COLS'($urandom);
            step();
            n_cmp++;
            if (dot_row !== e_row || dot_col !== e_col || frame_start !== e_fs || swap_pend !== m_pend) begin
                n_bad++;
                $display("FAIL random n=%0d row %h/%h col %h/%h fs %b/%b pend %b/%b", n, dot_row, e_row, dot_col, e_col, frame_start, e_fs, swap_pend, m_pend);
            end
        end
        idle_inputs();
        blink_en = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int k = 0; k < 2 * FRM && m_pend; k++) step();
        for (int r = 0; r < ROWS; r++) begin
            wr_en = 1; wr_row = 4'(r); wr_data = 14'h1555 | 14'(r + 1);
            step();
        end
        idle_inputs();
        wait_row(2, ok);
        swap_req = 1; step(); swap_req = 0;
        wait_row(5, ok);
        n_cmp++;
        if (!ok || swap_pend !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_setup pend %b row %0d", swap_pend, cur_row());
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (dot_row !== 10'd1 || dot_col !== 14'd0 || swap_pend !== 1'b0 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async row %h col %h pend %b fs %b", dot_row, dot_col, swap_pend, frame_start);
        end
        m_reset();
        @(negedge freq);
        rst = 0;
        for (int i = 0; i < 2 * FRM + 5; i++) begin
            step();
            n_cmp++;
            if (dot_col !== 14'd0 || swap_pend !== 1'b0 || dot_row !== e_row || frame_start !== e_fs) begin
                n_bad++;
                $display("FAIL reset_mid_after n=%0d col %h pend %b row %h/%h fs %b/%b", n, dot_col, swap_pend, dot_row, e_row, frame_start, e_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_no_swap();
        test_swap();
        test_double_swap();
        test_blink();
        do_reset();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
